// File: rtl/tictactoe_game_ctrl.sv
// tictactoe_game_ctrl: board owner and turn sequencer for the VGA tic-tac-toe game.
// Accepts committed moves, alternates P1/P2, detects wins and draws, and drives
// registered occupancy masks plus game status to the sprite and pointer printers.
// Optional feature: define TURN_TIMEOUT_EN to enable the per-turn timer that forces
// an automatic move into the lowest-index free cell when a player stalls.
//
// Handshake: move_valid is a single-cycle request with no back-pressure. Every
// move_valid that is not overridden by new_game is answered on the next edge by
// exactly one single-cycle pulse, move_ack (cell taken) or move_reject (refused).
// new_game wins over move_valid and produces neither pulse.
module tictactoe_game_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
    parameter int unsigned CNT_W          = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic [8:0] board_p1,
    output logic [8:0] board_p2,
    output logic       turn,
    output logic       move_ack,
    output logic       move_reject,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [7:0] win_lines,
    output logic       timeout,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_TURN  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    // The timer must be able to represent its last count.
    if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES) || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("tictactoe_game_ctrl: CNT_W too small for TIMEOUT_CYCLES");
    end

    state_t     state, state_nxt;
    logic [8:0] p1_nxt, p2_nxt;
    logic       turn_nxt, ack_nxt, rej_nxt, over_nxt, timeout_nxt;
    logic [1:0] winner_nxt;
    logic [7:0] lines_nxt;

    logic [8:0]  occupied;
    logic [15:0] occ16;
    logic        cell_ok;
    logic [8:0]  cell_mask;
    logic [8:0]  mover;
    logic [7:0]  hits;

`ifdef TURN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] timer, timer_nxt;
    logic [8:0]       free_cells;
    logic [8:0]       auto_mask;
`endif

    assign dbg_state = state;

    // Move legality, the requested cell, and the triples held by the player who just moved.
    always_comb begin
        occupied  = board_p1 | board_p2;
        // Indices 9..15 read as occupied so a single lookup rejects them.
        occ16     = {7'h7f, occupied};
        cell_ok   = !occ16[move_pos];
        cell_mask = 9'b1 << move_pos;
        mover     = turn ? board_p2 : board_p1;
        hits[0]   = mover[0] & mover[1] & mover[2];
        hits[1]   = mover[3] & mover[4] & mover[5];
        hits[2]   = mover[6] & mover[7] & mover[8];
        hits[3]   = mover[0] & mover[3] & mover[6];
        hits[4]   = mover[1] & mover[4] & mover[7];
        hits[5]   = mover[2] & mover[5] & mover[8];
        hits[6]   = mover[0] & mover[4] & mover[8];
        hits[7]   = mover[2] & mover[4] & mover[6];
    end

`ifdef TURN_TIMEOUT_EN
    // Lowest-index free cell isolated as a one-hot mask (x & -x).
    always_comb begin
        free_cells = ~occupied;
        auto_mask  = free_cells & (~free_cells + 9'd1);
    end
`endif

    // Next-state and next-output logic for the TURN/CHECK/OVER sequencer.
    always_comb begin
        state_nxt   = state;
        p1_nxt      = board_p1;
        p2_nxt      = board_p2;
        turn_nxt    = turn;
        ack_nxt     = 1'b0;
        rej_nxt     = 1'b0;
        over_nxt    = game_over;
        winner_nxt  = winner;
        lines_nxt   = win_lines;
        timeout_nxt = 1'b0;

        if (new_game) begin
            state_nxt  = ST_TURN;
            p1_nxt     = '0;
            p2_nxt     = '0;
            turn_nxt   = 1'b0;
            over_nxt   = 1'b0;
            winner_nxt = 2'b00;
            lines_nxt  = '0;
        end else begin
            case (state)
                ST_TURN: begin
                    if (move_valid) begin
                        if (cell_ok) begin
                            if (turn) p2_nxt = board_p2 | cell_mask;
                            else      p1_nxt = board_p1 | cell_mask;
                            ack_nxt   = 1'b1;
                            state_nxt = ST_CHECK;
                        end else begin
                            rej_nxt = 1'b1;
                        end
                    end
`ifdef TURN_TIMEOUT_EN
                    else if (timer == TIMER_LAST) begin
                        if (turn) p2_nxt = board_p2 | auto_mask;
                        else      p1_nxt = board_p1 | auto_mask;
                        ack_nxt     = 1'b1;
                        timeout_nxt = 1'b1;
                        state_nxt   = ST_CHECK;
                    end
`endif
                end
                ST_CHECK: begin
                    rej_nxt = move_valid;
                    if (|hits) begin
                        state_nxt  = ST_OVER;
                        over_nxt   = 1'b1;
                        winner_nxt = turn ? 2'b10 : 2'b01;
                        lines_nxt  = hits;
                    end else if (&occupied) begin
                        state_nxt  = ST_OVER;
                        over_nxt   = 1'b1;
                        winner_nxt = 2'b11;
                        lines_nxt  = '0;
                    end else begin
                        turn_nxt  = ~turn;
                        state_nxt = ST_TURN;
                    end
                end
                ST_OVER: begin
                    rej_nxt = move_valid;
                end
                default: begin
                    state_nxt = ST_TURN;
                end
            endcase
        end
    end

`ifdef TURN_TIMEOUT_EN
    // Turn timer: runs only while staying in TURN, so every entry to TURN starts from zero.
    always_comb begin
        timer_nxt = '0;
        if (!new_game && state == ST_TURN && state_nxt == ST_TURN) begin
            timer_nxt = timer + 1'b1;
        end
    end

    // Turn timer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) timer <= '0;
        else      timer <= timer_nxt;
    end
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_TURN;
            board_p1    <= '0;
            board_p2    <= '0;
            turn        <= 1'b0;
            move_ack    <= 1'b0;
            move_reject <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 2'b00;
            win_lines   <= '0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            board_p1    <= p1_nxt;
            board_p2    <= p2_nxt;
            turn        <= turn_nxt;
            move_ack    <= ack_nxt;
            move_reject <= rej_nxt;
            game_over   <= over_nxt;
            winner      <= winner_nxt;
            win_lines   <= lines_nxt;
            timeout     <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// Directed bench for tictactoe_game_ctrl: win/draw/reject/priority scenarios and,
// when TURN_TIMEOUT_EN is defined, the forced-move timer with a 16-cycle limit.
module tb_tictactoe_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_game = 1'b0;
    logic       move_valid = 1'b0;
    logic [3:0] move_pos = 4'd0;
    logic [8:0] board_p1, board_p2;
    logic       turn, move_ack, move_reject, game_over, timeout;
    logic [1:0] winner, dbg_state;
    logic [7:0] win_lines;

    int total = 0;
    int bad   = 0;
    logic [3:0] seq [9];

    tictactoe_game_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(28)) dut (
        .clk        (clk),
        .rst        (rst),
        .new_game   (new_game),
        .move_valid (move_valid),
        .move_pos   (move_pos),
        .board_p1   (board_p1),
        .board_p2   (board_p2),
        .turn       (turn),
        .move_ack   (move_ack),
        .move_reject(move_reject),
        .game_over  (game_over),
        .winner     (winner),
        .win_lines  (win_lines),
        .timeout    (timeout),
        .dbg_state  (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One move pulse; checks the ack/reject answer and lets CHECK complete.
    task automatic do_move(input logic [3:0] pos, input logic exp_ack, input string tag);
        @(negedge clk);
        move_valid = 1'b1;
        move_pos   = pos;
        @(negedge clk);
        move_valid = 1'b0;
        check({tag, "_ack"}, {31'd0, move_ack}, {31'd0, exp_ack});
        check({tag, "_rej"}, {31'd0, move_reject}, {31'd0, !exp_ack});
        @(negedge clk);
    endtask

    task automatic play_seq(input int n, input string tag);
        for (int i = 0; i < n; i++) do_move(seq[i], 1'b1, tag);
    endtask

    task automatic start_game(input string tag);
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check({tag, "_ng_p1"}, 32'(board_p1), 32'h0);
        check({tag, "_ng_p2"}, 32'(board_p2), 32'h0);
        check({tag, "_ng_over"}, {31'd0, game_over}, 32'd0);
        check({tag, "_ng_turn"}, {31'd0, turn}, 32'd0);
    endtask

    task automatic check_end(input string tag, input logic [8:0] p1, input logic [8:0] p2,
                             input logic [1:0] win, input logic [7:0] lines);
        check({tag, "_p1"}, 32'(board_p1), 32'(p1));
        check({tag, "_p2"}, 32'(board_p2), 32'(p2));
        check({tag, "_winner"}, 32'(winner), 32'(win));
        check({tag, "_lines"}, 32'(win_lines), 32'(lines));
        check({tag, "_over"}, {31'd0, game_over}, 32'd1);
    endtask

    initial begin
        // reset
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_p1", 32'(board_p1), 32'h0);
        check("rst_p2", 32'(board_p2), 32'h0);
        check("rst_turn", {31'd0, turn}, 32'd0);
        check("rst_ack", {31'd0, move_ack}, 32'd0);
        check("rst_rej", {31'd0, move_reject}, 32'd0);
        check("rst_over", {31'd0, game_over}, 32'd0);
        check("rst_winner", 32'(winner), 32'd0);
        check("rst_lines", 32'(win_lines), 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b1;

        // P1 wins top row
        do_move(4'd0, 1'b1, "w1_m0");
        check("w1_turn_after_p1", {31'd0, turn}, 32'd1);
        check("w1_p1_after_m0", 32'(board_p1), 32'h001);
        seq = '{4'd3, 4'd1, 4'd4, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        play_seq(4, "w1");
        check_end("w1", 9'h007, 9'h018, 2'b01, 8'h01);
        do_move(4'd5, 1'b0, "w1_over_move");
        check("w1_over_held_p2", 32'(board_p2), 32'h018);

        // P2 wins middle row
        start_game("p2w");
        seq = '{4'd0, 4'd3, 4'd1, 4'd4, 4'd8, 4'd5, 4'd0, 4'd0, 4'd0};
        play_seq(6, "p2w");
        check_end("p2w", 9'h103, 9'h038, 2'b10, 8'h02);
        check("p2w_turn", {31'd0, turn}, 32'd1);

        // rejects: occupied cell, out-of-range index, move during CHECK
        start_game("rej");
        do_move(4'd4, 1'b1, "rej_p1_4");
        do_move(4'd4, 1'b0, "rej_occupied");
        check("rej_turn", {31'd0, turn}, 32'd1);
        check("rej_p2", 32'(board_p2), 32'h0);
        do_move(4'd9, 1'b0, "rej_pos9");
        do_move(4'd15, 1'b0, "rej_pos15");
        @(negedge clk);
        move_valid = 1'b1;
        move_pos   = 4'd0;
        @(negedge clk);
        move_pos   = 4'd1;
        check("chk_first_ack", {31'd0, move_ack}, 32'd1);
        @(negedge clk);
        move_valid = 1'b0;
        check("chk_second_rej", {31'd0, move_reject}, 32'd1);
        check("chk_second_ack", {31'd0, move_ack}, 32'd0);
        check("chk_p2", 32'(board_p2), 32'h001);
        check("chk_turn", {31'd0, turn}, 32'd0);

        // draw
        start_game("draw");
        seq = '{4'd0, 4'd4, 4'd8, 4'd2, 4'd6, 4'd3, 4'd5, 4'd7, 4'd1};
        play_seq(9, "draw");
        check_end("draw", 9'h163, 9'h09C, 2'b11, 8'h00);

        // P1 wins on the 9th move via diagonal 0-4-8
        start_game("d9");
        seq = '{4'd2, 4'd1, 4'd7, 4'd3, 4'd0, 4'd5, 4'd4, 4'd6, 4'd8};
        play_seq(9, "d9");
        check_end("d9", 9'h195, 9'h06A, 2'b01, 8'h40);

        // double win (row 0 and column 0) on a full board
        start_game("dbl");
        seq = '{4'd1, 4'd4, 4'd2, 4'd5, 4'd3, 4'd7, 4'd6, 4'd8, 4'd0};
        play_seq(9, "dbl");
        check_end("dbl", 9'h04F, 9'h1B0, 2'b01, 8'h09);

        // new_game beats a same-cycle move
        start_game("pri");
        do_move(4'd0, 1'b1, "pri_m0");
        @(negedge clk);
        new_game   = 1'b1;
        move_valid = 1'b1;
        move_pos   = 4'd1;
        @(negedge clk);
        new_game   = 1'b0;
        move_valid = 1'b0;
        check("pri_ack", {31'd0, move_ack}, 32'd0);
        check("pri_rej", {31'd0, move_reject}, 32'd0);
        check("pri_p1", 32'(board_p1), 32'h0);
        check("pri_p2", 32'(board_p2), 32'h0);
        check("pri_turn", {31'd0, turn}, 32'd0);

        // async reset while in CHECK
        @(negedge clk);
        move_valid = 1'b1;
        move_pos   = 4'd0;
        @(negedge clk);
        move_valid = 1'b0;
        check("mr_in_check", 32'(dbg_state), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mr_p1", 32'(board_p1), 32'h0);
        check("mr_ack", {31'd0, move_ack}, 32'd0);
        check("mr_state", 32'(dbg_state), 32'd0);
        check("mr_turn", {31'd0, turn}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        do_move(4'd0, 1'b1, "mr_resume");

        // turn timer
        start_game("to");
        do_move(4'd0, 1'b1, "to_m0");
        do_move(4'd1, 1'b1, "to_m1");
        begin
            int   cyc  = 0;
            logic seen = 1'b0;
            while (!seen && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (timeout) seen = 1'b1;
            end
`ifdef TURN_TIMEOUT_EN
            check("to_seen", {31'd0, seen}, 32'd1);
            check("to_cycles", 32'(cyc), 32'd16);
            check("to_ack", {31'd0, move_ack}, 32'd1);
            check("to_p1", 32'(board_p1), 32'h005);
            @(negedge clk);
            check("to_pulse_end", {31'd0, timeout}, 32'd0);
            check("to_turn", {31'd0, turn}, 32'd1);
            repeat (15) @(negedge clk);
            move_valid = 1'b1;
            move_pos   = 4'd8;
            @(negedge clk);
            move_valid = 1'b0;
            check("race_ack", {31'd0, move_ack}, 32'd1);
            check("race_timeout", {31'd0, timeout}, 32'd0);
            check("race_p2", 32'(board_p2), 32'h102);
`else
            check("to_never", {31'd0, seen}, 32'd0);
            check("to_p1_held", 32'(board_p1), 32'h001);
            check("to_turn_held", {31'd0, turn}, 32'd0);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
